montlift_32: RTL and testbench
==============================

// Module: montlift_32
// PURPOSE
//  Serial Montgomery-domain entry converter: inverse direction of the word-level reduction stage.
//  - The reduction stage divides by 2^13 mod q per word.
//  - This block multiplies by 2^(13*L_ROUNDS) mod q, so that T = A*R mod q with R = 2^(13*L_ROUNDS).
//  - Sits in front of the BU datapath and lifts twiddles/coefficients before they enter the reduction chain.
//  - q = {qH, 13'd1} = qH*2^13 + 1, with qH[18] = 1, so 2^31 < q < 2^32.
// PARAMETERS
//  L_ROUNDS   2   number of 13-bit words; total doublings N = 13*L_ROUNDS (0 allowed: reduce only)
//  Q_WIDTH    32  coefficient/modulus width
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-low (rst==0 resets at the clock edge)
//  qH         in   19  modulus high part, sampled on input handshake
//  in_valid   in   1   operand A valid
//  in_ready   out  1   block can accept A
//  A          in   32  operand, any 32-bit value (need not be < q)
//  out_valid  out  1   T valid
//  out_ready  in   1   downstream accepts T
//  T          out  32  A*2^(13*L_ROUNDS) mod q, in [0, q-1]
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE; out_valid=0, T=0, busy=0, in_ready=1; cnt=0, q_reg=0.
//  FSM states: IDLE -> PREP -> SHIFT (N cycles) -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid&in_ready: x<=A, q_reg<={qH,13'd1}, go PREP.
//   PREP : x <= (x>=q_reg) ? x-q_reg : x. One subtraction suffices because A < 2^32 < 2q.
//          cnt<=N. If N==0 go DONE, else go SHIFT.
//   SHIFT: x <= mod_dbl(x), cnt<=cnt-1; after the update with cnt==1, go DONE.
//   DONE : out_valid=1, T=x held stable. On out_ready go IDLE with out_valid=0 at next edge.
//  Doubling arithmetic:
//   - y = {x,1'b0} is 33 bits; result = (y>=q) ? y-q : y.
//   - Compare/subtract at 33 bits; never truncate before the compare.
//   - Invariant x < q holds after PREP and after every SHIFT.
//  Latency: out_valid rises N+2 edges after the accept edge (28 for L_ROUNDS=2).
//   Throughput: 1 result per N+3 cycles with out_ready held high.
//  No input acceptance outside IDLE (in_ready=0), so there is no accept/output overlap.
//   A and qH may change freely while busy.
//  Backpressure: DONE holds indefinitely while out_ready=0; T must not change.
//  Reset mid-operation (any state): abort; next edge IDLE with outputs at reset values. No partial result emitted.
//  qH[18]==0 is illegal; behaviour is unspecified (bench must not drive it).
// STRUCTURE
//  Shared package (bu_pkg):
//   - W_WORD=13, QH_WIDTH=19, Q_WIDTH=32
//   - state enum {IDLE,PREP,SHIFT,DONE}
//   - function make_q(qH) = {qH, 13'd1}
//  Sub-module moddbl_32: combinational 2x mod q (33-bit compare/subtract).
//   Also instantiated by PREP with the shift bypassed (sub-only mode input).
//  Top: FSM, cnt ($clog2(N+1) bits, minimum 1), x/q_reg registers, handshake logic.
// TESTING  (qH=19'h40001 -> q=0x80002001, L_ROUNDS=1 unless noted)
//  1 A=1 -> T=0x00002000 after 15 edges; out_valid held until out_ready.
//  2 A=q-1=0x80002000 -> T=q-8192=0x80000001 (-1*2^13 mod q).
//  3 A=0x80002001 (=q) -> PREP yields 0; T=0. A=0 -> T=0.
//  4 A=0xFFFFFFFF, L_ROUNDS=2 -> T equals golden (A*2^26) mod q.
//    Plus 10k random A/qH (qH[18]=1) compared against a bignum model.
//  5 out_ready=0 for 5 cycles in DONE -> T, out_valid stable; in_ready=0; in_valid pulses ignored.
//  6 rst=0 on 5th SHIFT cycle -> next edge IDLE, out_valid=0, busy=0, in_ready=1.
//    A fresh A=1 then yields T=0x2000.

Source files
------------

// File: rtl/bu_pkg.sv
// Shared definitions for the Montgomery lift / reduction datapath:
// word width, modulus widths, FSM state encoding and modulus construction.
package bu_pkg;

    localparam int W_WORD   = 13;
    localparam int QH_WIDTH = 19;
    localparam int Q_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The low word of q is fixed to 1, so only the high part is transported.
    function automatic logic [Q_WIDTH-1:0] make_q(input logic [QH_WIDTH-1:0] qh);
        return {qh, 13'd1};
    endfunction

endpackage

// File: rtl/moddbl_32.sv
// Combinational modular doubling (or plain conditional subtract when sub_only
// is set). Works at Q_WIDTH+1 bits so the doubled value is never truncated.
module moddbl_32
    import bu_pkg::*;
(
    input  logic [Q_WIDTH-1:0] x,
    input  logic [Q_WIDTH-1:0] q,
    input  logic               sub_only,
    output logic [Q_WIDTH-1:0] r
);

    logic [Q_WIDTH:0] y_s;
    logic [Q_WIDTH:0] q_ext_s;
    logic [Q_WIDTH:0] diff_s;

    // One conditional subtraction; caller guarantees y < 2q.
    always_comb begin
        y_s     = {1'b0, x};
        q_ext_s = {1'b0, q};
        if (sub_only) begin
            y_s = {1'b0, x};
        end else begin
            y_s = {x, 1'b0};
        end
        diff_s = y_s - q_ext_s;
        if (y_s >= q_ext_s) begin
            r = diff_s[Q_WIDTH-1:0];
        end else begin
            r = y_s[Q_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/montlift_32.sv
// Serial Montgomery-domain entry converter: T = A * 2^(13*L_ROUNDS) mod q,
// computed by one reduction step followed by N modular doublings.
module montlift_32
    import bu_pkg::*;
#(
    parameter int L_ROUNDS = 2,
    parameter int Q_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [18:0]         qH,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Q_WIDTH-1:0]  A,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Q_WIDTH-1:0]  T,
    output logic                busy
);

    localparam int N_DBL = W_WORD * L_ROUNDS;
    localparam int CNT_W = (N_DBL == 0) ? 1 : $clog2(N_DBL + 1);

    state_t             state_q, state_d;
    logic [Q_WIDTH-1:0] x_q, x_d;
    logic [Q_WIDTH-1:0] q_reg_q, q_reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [Q_WIDTH-1:0] t_q, t_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic [Q_WIDTH-1:0] mod_r_s;
    logic               sub_only_s;

    assign sub_only_s = (state_q == PREP);

    moddbl_32 u_dbl (
        .x        (x_q),
        .q        (q_reg_q),
        .sub_only (sub_only_s),
        .r        (mod_r_s)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        q_reg_d     = q_reg_q;
        cnt_d       = cnt_q;
        t_d         = t_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = A;
                    q_reg_d = make_q(qH);
                    state_d = PREP;
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                // A < 2^32 < 2q, so a single subtract lands in [0, q-1].
                x_d   = mod_r_s;
                cnt_d = CNT_W'(N_DBL);
                if (N_DBL == 0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                x_d   = mod_r_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // T is captured once on entry to DONE and held until the next result.
        if ((state_d == DONE) && (state_q != DONE)) begin
            t_d = x_d;
        end else begin
            t_d = t_q;
        end
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            q_reg_q     <= '0;
            cnt_q       <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            q_reg_q     <= q_reg_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign T         = t_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_montlift_32.sv
// Directed bench for montlift_32: one instance with L_ROUNDS=1 (index 0)
// and one with L_ROUNDS=2 (index 1), sharing clock and reset.
module tb_montlift_32;

    localparam logic [18:0] QH0 = 19'h40001;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  busy;
    logic [31:0] a_v [2];
    logic [31:0] t_v [2];
    logic [18:0] qh_v [2];

    int n_cmp;
    int n_err;

    montlift_32 #(.L_ROUNDS(1), .Q_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .qH(qh_v[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .A(a_v[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .T(t_v[0]), .busy(busy[0])
    );

    montlift_32 #(.L_ROUNDS(2), .Q_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .qH(qh_v[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .A(a_v[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .T(t_v[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: (A mod q) * 2^n mod q in 64-bit arithmetic (n <= 26).
    function automatic logic [31:0] gold(input logic [31:0] a, input logic [18:0] qh, input int n);
        longint unsigned q;
        longint unsigned r;
        q = {45'd0, qh, 13'd1};
        r = {32'd0, a} % q;
        r = (r << n) % q;
        return r[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance s; hold = cycles of out_ready=0 in DONE.
    task automatic xact(input int s, input logic [31:0] a, input logic [18:0] qh,
                        input logic [31:0] exp, input int hold, input string tag);
        int k;
        int nd;
        logic [31:0] t_seen;
        nd = 13 * (s + 1);
        chk1({tag, ".in_ready_idle"}, in_ready[s], 1'b1);
        in_valid[s] = 1'b1;
        a_v[s]      = a;
        qh_v[s]     = qh;
        tick();
        in_valid[s] = 1'b0;
        a_v[s]      = $urandom;
        qh_v[s]     = {1'b1, 18'($urandom)};
        chk1({tag, ".busy"}, busy[s], 1'b1);
        chk1({tag, ".in_ready_busy"}, in_ready[s], 1'b0);
        k = 0;
        while (out_valid[s] !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        // edges counted including the accept edge
        chk32({tag, ".latency"}, 32'(k + 1), 32'(nd + 2));
        chk32({tag, ".T"}, t_v[s], exp);
        t_seen = t_v[s];
        for (int i = 0; i < hold; i++) begin
            in_valid[s] = 1'b1;
            a_v[s]      = $urandom;
            tick();
            in_valid[s] = 1'b0;
            chk1({tag, ".hold_valid"}, out_valid[s], 1'b1);
            chk32({tag, ".hold_T"}, t_v[s], t_seen);
            chk1({tag, ".hold_in_ready"}, in_ready[s], 1'b0);
        end
        out_ready[s] = 1'b1;
        tick();
        out_ready[s] = 1'b0;
        chk1({tag, ".drop_valid"}, out_valid[s], 1'b0);
        chk1({tag, ".idle_busy"}, busy[s], 1'b0);
        chk1({tag, ".idle_in_ready"}, in_ready[s], 1'b1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [18:0] rq;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        in_valid = 2'b00;
        out_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            a_v[i]  = 32'd0;
            qh_v[i] = QH0;
        end
        repeat (3) tick();

        // Reset state on both instances
        for (int i = 0; i < 2; i++) begin
            chk1("rst.out_valid", out_valid[i], 1'b0);
            chk32("rst.T", t_v[i], 32'd0);
            chk1("rst.busy", busy[i], 1'b0);
            chk1("rst.in_ready", in_ready[i], 1'b1);
        end
        rst = 1'b1;
        tick();

        // q = 0x80002001, L_ROUNDS=1
        xact(0, 32'h0000_0001, QH0, 32'h0000_2000, 2, "t1_one");
        xact(0, 32'h8000_2000, QH0, 32'h8000_0001, 0, "t2_qm1");
        xact(0, 32'h8000_2001, QH0, 32'h0000_0000, 0, "t3_q");
        xact(0, 32'h0000_0000, QH0, 32'h0000_0000, 0, "t3_zero");
        xact(0, 32'hFFFF_FFFF, QH0, gold(32'hFFFF_FFFF, QH0, 13), 0, "t4_max_l1");
        xact(1, 32'hFFFF_FFFF, QH0, gold(32'hFFFF_FFFF, QH0, 26), 0, "t4_max_l2");
        xact(1, 32'h0000_0001, QH0, 32'h0400_0000, 0, "t4_one_l2");
        xact(0, 32'h0000_0005, QH0, 32'h0000_A000, 5, "t5_backpressure");

        // Random operands against the 64-bit reference
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rq = {1'b1, 18'($urandom)};
            xact(1, ra, rq, gold(ra, rq, 26), 0, "rnd_l2");
            ra = $urandom;
            rq = {1'b1, 18'($urandom)};
            xact(0, ra, rq, gold(ra, rq, 13), 0, "rnd_l1");
        end

        // Abort during the 5th SHIFT cycle
        in_valid[0] = 1'b1;
        a_v[0]      = 32'h0000_0003;
        qh_v[0]     = QH0;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        chk1("t6.busy_pre", busy[0], 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk1("t6.out_valid", out_valid[0], 1'b0);
        chk1("t6.busy", busy[0], 1'b0);
        chk1("t6.in_ready", in_ready[0], 1'b1);
        chk32("t6.T", t_v[0], 32'd0);
        chk32("t6.T_l2", t_v[1], 32'd0);
        xact(0, 32'h0000_0001, QH0, 32'h0000_2000, 0, "t6_fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
